// File: rtl/ft_host_pkg.sv
// Shared FT245 host-interface definitions: arbiter state encoding, default
// watchdog threshold and a constant-width helper.
package ft_host_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int FT_TIMEOUT_DEFAULT = 1024;

  // Ceiling log2 for elaboration-time width derivation; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ft_out_arbiter_if.sv
// Requester/out-FIFO bundle for the out-FIFO arbiter. The slave modport is the
// arbiter side; the master modport is the requester/FIFO side.
interface ft_out_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_fifo_wr;
  logic [7:0]           out_fifo_data;
  logic                 out_fifo_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 timeout_stb;
  logic [2:0]           timeout_id;

  modport master (
    output req_valid, req_data, req_last, out_fifo_full,
    input  req_ready, out_fifo_wr, out_fifo_data, grant, busy, timeout_stb, timeout_id
  );

  modport slave (
    input  req_valid, req_data, req_last, out_fifo_full,
    output req_ready, out_fifo_wr, out_fifo_data, grant, busy, timeout_stb, timeout_id
  );
endinterface

// File: rtl/ft_rr_select.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Shared with the in-FIFO command dispatcher.
module ft_rr_select
  import ft_host_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found_s;
  logic             take_s;
  logic [IDX_W-1:0] cand_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (s >= N) ? IDX_W'(s - N) : IDX_W'(s);
  endfunction

  // Scan N candidates starting at ptr; the first valid one wins.
  always_comb begin
    pick    = '0;
    idx     = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s       = wrap_idx(ptr, k);
      take_s       = req[cand_s] && !found_s;
      pick[cand_s] = take_s;
      idx          = take_s ? cand_s : idx;
      found_s      = found_s || take_s;
    end
  end

  assign any = |req;

endmodule

// File: rtl/ft_out_arbiter.sv
// Packet-granular round-robin arbiter for the FT245 out-FIFO write port, with a
// stall watchdog that reclaims the port from an owner that stops mid-packet.
module ft_out_arbiter
  import ft_host_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = FT_TIMEOUT_DEFAULT,
  parameter int TO_W    = clog2(TIMEOUT + 1)
) (
  input logic                clk,
  input logic                rst,
  ft_out_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

  arb_state_t         state_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [TO_W-1:0]    stall_r;
  logic               tstb_r;
  logic [2:0]         tid_r;

  logic [NUM_REQ-1:0] sel_pick_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               sel_any_s;

  logic               own_valid_s;
  logic               own_last_s;
  logic [7:0]         own_data_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               wr_s;
  logic [7:0]         data_s;

  ft_rr_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req  (bus.req_valid),
    .ptr  (ptr_r),
    .pick (sel_pick_s),
    .idx  (sel_idx_s),
    .any  (sel_any_s)
  );

  assign own_valid_s = bus.req_valid[owner_r];
  assign own_last_s  = bus.req_last[owner_r];
  assign own_data_s  = bus.req_data[{owner_r, 3'b000} +: 8];
  assign next_ptr_s  = (owner_r == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : owner_r + IDX_W'(1);

  // Zero-latency write path from the owner to the FIFO; silenced during reset.
  always_comb begin
    ready_s = '0;
    wr_s    = 1'b0;
    data_s  = 8'h00;
    if ((state_r == ARB_GRANT) && !rst) begin
      ready_s[owner_r] = !bus.out_fifo_full;
      wr_s             = own_valid_s && !bus.out_fifo_full;
      data_s           = wr_s ? own_data_s : 8'h00;
    end else begin
      ready_s = '0;
      wr_s    = 1'b0;
      data_s  = 8'h00;
    end
  end

  // Arbitration FSM, round-robin pointer and stall watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      grant_r <= '0;
      stall_r <= '0;
      tstb_r  <= 1'b0;
      tid_r   <= 3'd0;
    end else begin
      tstb_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (sel_any_s) begin
            state_r <= ARB_GRANT;
            owner_r <= sel_idx_s;
            grant_r <= sel_pick_s;
            stall_r <= '0;
          end else begin
            grant_r <= '0;
          end
        end
        ARB_GRANT: begin
          if (wr_s) begin
            stall_r <= '0;
            if (own_last_s) begin
              state_r <= ARB_IDLE;
              grant_r <= '0;
              ptr_r   <= next_ptr_s;
            end else begin
              state_r <= ARB_GRANT;
            end
          end else if (!own_valid_s) begin
            // A full FIFO with a valid owner lands in neither branch: not a stall.
            if (stall_r == TO_W'(TIMEOUT - 1)) begin
              state_r <= ARB_IDLE;
              grant_r <= '0;
              ptr_r   <= next_ptr_s;
              stall_r <= '0;
              tstb_r  <= 1'b1;
              tid_r   <= 3'(owner_r);
            end else begin
              stall_r <= stall_r + TO_W'(1);
            end
          end else begin
            stall_r <= stall_r;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready_s;
  assign bus.out_fifo_wr   = wr_s;
  assign bus.out_fifo_data = data_s;
  assign bus.grant         = grant_r;
  assign bus.busy          = (state_r == ARB_GRANT);
  assign bus.timeout_stb   = tstb_r;
  assign bus.timeout_id    = tid_r;

endmodule

// File: doc/ft_out_arbiter.md
Name: ft_out_arbiter

Overview:
- Shares the FT245 host-interface out-FIFO write port (out_fifo_wr / out_fifo_data / out_fifo_full, clk domain) between NUM_REQ byte-stream requesters, e.g. a command-response generator and an interrupt reporter.
- Grants whole packets round-robin, so bytes from different packets never interleave on the USB stream.
- A stall watchdog reclaims the port from a requester that stops supplying data mid-packet.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 1024, consecutive requester-stall cycles before a forced release (>= 2).
- TO_W, 11, width of the stall counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  host clock, same domain as the out-FIFO write side.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  out  NUM_REQ  byte accepted this cycle when valid && ready.
- out_fifo_wr  out  1  write strobe to the out FIFO.
- out_fifo_data  out  8  byte to the out FIFO.
- out_fifo_full  in  1  out-FIFO full flag.
- grant  out  NUM_REQ  one-hot owner of the port; zero when idle.
- busy  out  1  high while any grant is held.
- timeout_stb  out  1  one-cycle pulse on a forced release.
- timeout_id  out  3  index of the requester that timed out; holds until the next timeout.

Behaviour:
- Reset: state IDLE; grant=0; busy=0; req_ready=0; out_fifo_wr=0; out_fifo_data=0; timeout_stb=0; timeout_id=0; rr pointer=0, so requester 0 has top priority; stall counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first valid index searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - Register grant for that index and go to GRANT next cycle. Arbitration costs exactly 1 cycle.
  - No bytes transfer in IDLE.
- GRANT (owner g):
  - req_ready[g] = !out_fifo_full; all other req_ready are 0. This is combinational.
  - out_fifo_wr = req_valid[g] && !out_fifo_full; out_fifo_data = req_data[g]. Both combinational, zero latency, never written while full.
  - out_fifo_data is 0 whenever out_fifo_wr is 0.
  - On an accepted beat with req_last[g]: return to IDLE next cycle, set rr pointer to (g+1) mod NUM_REQ, clear grant.
  - Minimum gap between packets is 1 idle cycle.
- Stall watchdog:
  - The counter increments each GRANT cycle in which req_valid[g]=0.
  - It resets to 0 on every accepted beat and on entry to GRANT.
  - Cycles stalled by out_fifo_full with req_valid[g]=1 do not count and do not reset the counter.
  - When the counter reaches TIMEOUT-1 and this cycle still has no valid byte: assert timeout_stb for 1 cycle, set timeout_id=g, set rr pointer to (g+1) mod NUM_REQ, go to IDLE.
  - The partial packet already in the FIFO is not retracted; host firmware handles it.
- Simultaneous events:
  - An accepted last beat and a threshold cycle in the same cycle cannot coincide, because acceptance resets the counter. Acceptance always wins.
  - If the owner raises req_valid while out_fifo_full is high, this counts as not stalled.
- Requesters must hold req_data and req_last stable while valid && !ready. The arbiter does not check this.
- A requester whose req_valid is low in IDLE is skipped. Only a valid requester is ever granted.
- Reset mid-packet returns immediately to IDLE with the pointer at 0. Bytes already written stay in the FIFO.

Decomposition:
- Shared package ft_host_pkg:
  - State enum: ARB_IDLE=0, ARB_GRANT=1.
  - Default TIMEOUT constant.
  - Function clog2 used to derive TO_W and the id width.
- Sub-module ft_rr_select (combinational):
  - Inputs: req vector and pointer.
  - Outputs: one-hot pick and index.
  - Reused later by the in-FIFO command dispatcher.

Test Plan:
- Single packet: after reset, req0 sends 0xA1,0xA2,0xA3 (last on 0xA3) with full=0 -> grant=01 the cycle after valid; three consecutive out_fifo_wr with the same bytes; busy drops the cycle after 0xA3.
- Round-robin: req0 and req1 both valid from reset, each with a 2-byte packet, req0 re-raising a packet immediately -> order req0, req1, req0; never two consecutive grants to req0 while req1 is waiting.
- Backpressure: full=1 for 5 cycles in the middle of req1's 4-byte packet 0x10..0x13 -> no out_fifo_wr and req_ready[1]=0 during full; all 4 bytes delivered in order; no timeout_stb even with TIMEOUT=4.
- Watchdog: TIMEOUT=4; req0 sends 0x55, then drops valid without last -> after 4 stalled cycles, timeout_stb=1 for 1 cycle, timeout_id=0, grant=0; pending req1 is granted next.
- Reset mid-packet: assert rst for 1 cycle after req1's second byte -> next cycle grant=0, busy=0, out_fifo_wr=0; with both requesting afterwards, req0 is granted first.
- No-interleave check: random valid/last/full patterns, 2000 cycles, NUM_REQ=3 -> scoreboard confirms every packet arrives contiguous and byte-exact, and no write occurs while full=1.
